// File: rtl/audio_pkg.sv
// Shared audio definitions: scheduler state encoding, sound IDs and timing defaults.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    PLAY    = 2'd2,
    GAP     = 2'd3
  } snd_state_e;

  localparam int unsigned SND_THEME        = 0;
  localparam int unsigned SND_SHOOT        = 1;
  localparam int unsigned SND_INVADER_HIT  = 2;
  localparam int unsigned SND_PLAYER_DEATH = 3;

  localparam int unsigned DEF_RST_CYC = 2;
  localparam int unsigned DEF_GAP_CYC = 4;

endpackage

// File: rtl/sound_prio_enc.sv
// Highest-set-index priority encoder; valid is low when no input bit is set.
module sound_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Ascending scan: the last set bit seen is the highest, so it wins.
    for (int i = 0; i < int'(N); i++) begin
      if (in_vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates game sound requests onto the shared I2S player's select/onOff interface,
// restarting the player between sounds and inserting a silent gap after each one.
module sound_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned RST_CYC     = DEF_RST_CYC,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic               MCLK,
  input  logic               nReset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               theme_en,
  input  logic               mute,
  input  logic               theme_ended,
  output logic [SEL_W-1:0]   select,
  output logic               onOff,
  output logic               play_rst_n,
  output logic               busy,
  output logic [SEL_W-1:0]   active_id
);

  snd_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, clr_mask;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   enc_idx, win_idx;
  logic               enc_valid, win_valid;
  logic [15:0]        cnt_q;
  logic [31:0]        timer_q;
  logic               rst_done_q;
  logic               grant;
  logic               preempt;
  logic               timeout_hit;

  sound_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (SEL_W)
  ) u_prio_enc (
    .in_vec (pend_q),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  // The theme only competes when nothing is pending; it never preempts anything.
  assign win_valid   = enc_valid | theme_en;
  assign win_idx     = enc_valid ? enc_idx : SEL_W'(SND_THEME);
  assign preempt     = enc_valid &&
                       ((enc_idx > sel_q) || ((enc_idx == sel_q) && (sel_q != '0)));
  assign timeout_hit = (timer_q == (TIMEOUT_CYC - 32'd1));

  // A request landing on the grant edge survives the clear, giving one retrigger.
  assign clr_mask = grant ? (NUM_SRC'(1) << win_idx) : '0;
  assign pend_d   = mute ? '0 : ((pend_q & ~clr_mask) | req);

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    if (mute) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_d = RESTART;
            grant   = 1'b1;
          end
        end
        RESTART: begin
          if (cnt_q <= 16'd1) state_d = PLAY;
        end
        PLAY: begin
          if (preempt) begin
            state_d = RESTART;
            grant   = 1'b1;
          end else if (theme_ended && (sel_q != '0)) begin
            state_d = GAP;
          end else if ((sel_q == '0) && !theme_en) begin
            state_d = GAP;
          end else if (timeout_hit) begin
            state_d = GAP;
          end
        end
        GAP: begin
          if (cnt_q == 16'd0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    onOff      = 1'b0;
    busy       = 1'b0;
    play_rst_n = rst_done_q;
    select     = sel_q;
    active_id  = sel_q;
    unique case (state_q)
      RESTART: begin
        busy       = 1'b1;
        play_rst_n = 1'b0;
      end
      PLAY: begin
        busy  = 1'b1;
        onOff = !mute;
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      pend_q     <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      rst_done_q <= 1'b1;
      if (grant) sel_q <= win_idx;

      // One counter serves both the restart pulse and the silence gap.
      if (grant) begin
        cnt_q <= 16'(RST_CYC);
      end else if ((state_d == GAP) && (state_q != GAP)) begin
        cnt_q <= 16'(GAP_CYC);
      end else if (((state_q == RESTART) || (state_q == GAP)) && (cnt_q != 16'd0)) begin
        cnt_q <= cnt_q - 16'd1;
      end

      if ((state_q == PLAY) && (state_d == PLAY)) begin
        if (timer_q != '1) timer_q <= timer_q + 32'd1;
      end else begin
        timer_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: theme looping, effects, priority, preemption,
// timeout, mute and asynchronous reset.
module tb_sound_scheduler;

  logic       MCLK;
  logic       nReset;
  logic [3:0] req;
  logic       theme_en;
  logic       mute;
  logic       theme_ended;
  logic [3:0] select;
  logic       onOff;
  logic       play_rst_n;
  logic       busy;
  logic [3:0] active_id;

  int checks = 0;
  int errors = 0;

  sound_scheduler #(
    .NUM_SRC     (4),
    .SEL_W       (4),
    .RST_CYC     (2),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (32'd100)
  ) dut (
    .MCLK        (MCLK),
    .nReset      (nReset),
    .req         (req),
    .theme_en    (theme_en),
    .mute        (mute),
    .theme_ended (theme_ended),
    .select      (select),
    .onOff       (onOff),
    .play_rst_n  (play_rst_n),
    .busy        (busy),
    .active_id   (active_id)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_sel(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_on, input logic e_prst,
                            input logic e_busy, input logic [3:0] e_sel);
    check({tag, ".onOff"}, onOff, e_on);
    check({tag, ".play_rst_n"}, play_rst_n, e_prst);
    check({tag, ".busy"}, busy, e_busy);
    check_sel({tag, ".select"}, select, e_sel);
    check_sel({tag, ".active_id"}, active_id, e_sel);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  initial begin
    nReset      = 1'b0;
    req         = '0;
    theme_en    = 1'b0;
    mute        = 1'b0;
    theme_ended = 1'b0;
    #2;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    #10;
    nReset = 1'b1;
    step(1);
    expect_out("post_reset", 1'b0, 1'b1, 1'b0, 4'd0);

    // Theme only: two restart cycles, then it loops through theme_ended pulses.
    theme_en = 1'b1;
    step(1); expect_out("theme_rst1", 1'b0, 1'b0, 1'b1, 4'd0);
    step(1); expect_out("theme_rst2", 1'b0, 1'b0, 1'b1, 4'd0);
    step(1); expect_out("theme_play", 1'b1, 1'b1, 1'b1, 4'd0);
    repeat (3) begin
      theme_ended = 1'b1; step(1); theme_ended = 1'b0;
      step(1); expect_out("theme_loop", 1'b1, 1'b1, 1'b1, 4'd0);
    end

    // Effect over theme: gap of GAP_CYC+1 cycles, one IDLE cycle, theme restarts.
    req = 4'b0010; step(1); req = '0;
    expect_out("eff_req", 1'b1, 1'b1, 1'b1, 4'd0);
    step(1); expect_out("eff_rst1", 1'b0, 1'b0, 1'b1, 4'd1);
    step(1); expect_out("eff_rst2", 1'b0, 1'b0, 1'b1, 4'd1);
    step(1); expect_out("eff_play", 1'b1, 1'b1, 1'b1, 4'd1);
    theme_ended = 1'b1; step(1); theme_ended = 1'b0;
    expect_out("eff_gap_first", 1'b0, 1'b1, 1'b0, 4'd1);
    step(4); expect_out("eff_gap_last", 1'b0, 1'b1, 1'b0, 4'd1);
    step(1); expect_out("eff_idle", 1'b0, 1'b1, 1'b0, 4'd1);
    step(1); expect_out("theme_resume_rst", 1'b0, 1'b0, 1'b1, 4'd0);
    step(2); expect_out("theme_resume_play", 1'b1, 1'b1, 1'b1, 4'd0);

    // Priority: simultaneous req[1] and req[3] -> 3, then 1, then theme.
    req = 4'b1010; step(1); req = '0;
    step(1); expect_out("prio_rst3", 1'b0, 1'b0, 1'b1, 4'd3);
    step(2); expect_out("prio_play3", 1'b1, 1'b1, 1'b1, 4'd3);
    step(1); expect_out("prio_hold3", 1'b1, 1'b1, 1'b1, 4'd3);
    theme_ended = 1'b1; step(1); theme_ended = 1'b0;
    step(5); expect_out("prio_idle", 1'b0, 1'b1, 1'b0, 4'd3);
    step(1); expect_out("prio_rst1", 1'b0, 1'b0, 1'b1, 4'd1);
    step(2); expect_out("prio_play1", 1'b1, 1'b1, 1'b1, 4'd1);
    theme_ended = 1'b1; step(1); theme_ended = 1'b0;
    step(5);
    step(1); expect_out("prio_theme_rst", 1'b0, 1'b0, 1'b1, 4'd0);
    step(2); expect_out("prio_theme_play", 1'b1, 1'b1, 1'b1, 4'd0);

    // Preemption of 2 by 3, then retrigger of 3; 2 must not come back.
    req = 4'b0100; step(1); req = '0;
    step(1); expect_out("pre_rst2", 1'b0, 1'b0, 1'b1, 4'd2);
    step(2); expect_out("pre_play2", 1'b1, 1'b1, 1'b1, 4'd2);
    req = 4'b1000; step(1); req = '0;
    expect_out("pre_req3", 1'b1, 1'b1, 1'b1, 4'd2);
    step(1); expect_out("pre_rst3", 1'b0, 1'b0, 1'b1, 4'd3);
    step(2); expect_out("pre_play3", 1'b1, 1'b1, 1'b1, 4'd3);
    req = 4'b1000; step(1); req = '0;
    step(1); expect_out("retrig_rst1", 1'b0, 1'b0, 1'b1, 4'd3);
    step(1); expect_out("retrig_rst2", 1'b0, 1'b0, 1'b1, 4'd3);
    step(1); expect_out("retrig_play", 1'b1, 1'b1, 1'b1, 4'd3);
    theme_ended = 1'b1; step(1); theme_ended = 1'b0;
    step(5);
    step(1); expect_out("pre_no_replay", 1'b0, 1'b0, 1'b1, 4'd0);
    step(2); expect_out("pre_theme_play", 1'b1, 1'b1, 1'b1, 4'd0);

    // Theme disabled ends the theme; then effect 1 runs into the 100-cycle timeout.
    theme_en = 1'b0;
    step(1); expect_out("theme_off_gap", 1'b0, 1'b1, 1'b0, 4'd0);
    step(5); expect_out("theme_off_idle", 1'b0, 1'b1, 1'b0, 4'd0);
    req = 4'b0010; step(1); req = '0;
    step(1); expect_out("to_rst", 1'b0, 1'b0, 1'b1, 4'd1);
    step(2); expect_out("to_play_first", 1'b1, 1'b1, 1'b1, 4'd1);
    step(99); expect_out("to_play_last", 1'b1, 1'b1, 1'b1, 4'd1);
    step(1); expect_out("to_gap", 1'b0, 1'b1, 1'b0, 4'd1);
    step(5); expect_out("to_idle", 1'b0, 1'b1, 1'b0, 4'd1);

    // Mute mid-PLAY: onOff drops at once, IDLE next edge, requests during mute are lost.
    theme_en = 1'b1;
    step(1); expect_out("mute_pre_rst", 1'b0, 1'b0, 1'b1, 4'd0);
    step(2); expect_out("mute_pre_play", 1'b1, 1'b1, 1'b1, 4'd0);
    mute = 1'b1; req = 4'b0100;
    #1; expect_out("mute_comb", 1'b0, 1'b1, 1'b1, 4'd0);
    step(1); req = '0;
    expect_out("mute_idle", 1'b0, 1'b1, 1'b0, 4'd0);
    step(1); expect_out("mute_hold", 1'b0, 1'b1, 1'b0, 4'd0);
    mute = 1'b0;
    step(1); expect_out("mute_lost_req", 1'b0, 1'b0, 1'b1, 4'd0);

    // Asynchronous reset while restarting effect 3.
    step(2); expect_out("arst_pre_play", 1'b1, 1'b1, 1'b1, 4'd0);
    req = 4'b1000; step(1); req = '0;
    step(1); expect_out("arst_rst3", 1'b0, 1'b0, 1'b1, 4'd3);
    nReset = 1'b0;
    #1; expect_out("arst_now", 1'b0, 1'b0, 1'b0, 4'd0);
    #2; nReset = 1'b1;
    step(1); expect_out("arst_release", 1'b0, 1'b0, 1'b1, 4'd0);
    step(2); expect_out("arst_theme_play", 1'b1, 1'b1, 1'b1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
